lcd_text_writer: RTL

Avalon-MM master that sits directly upstream of the LCD_IP character-LCD slave and replaces the fixed hello_lcd message driver. It accepts a byte stream over a valid/ready handshake and turns it into LCD instruction writes (address 0) and data writes (address 1). It runs the panel init sequence, tracks the cursor, wraps lines, and interprets newline and form-feed control characters.

---
 rtl/lcd_pkg.sv | 36 +++
 rtl/avm_single_write.sv | 59 +++++
 rtl/lcd_text_writer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and state encoding for the character-LCD text writer.
// Holds the HD44780-style instruction bytes, the recognised control characters,
// the Avalon address map of the LCD slave and the command-sequencer state enum.
package lcd_pkg;

  // LCD instruction bytes (written at the instruction address)
  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_ENTRY     = 8'h06;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_SET_DDRAM = 8'h80;

  // Control characters interpreted from the byte stream
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;

  // Avalon address map of the LCD slave
  localparam logic ADDR_INSTR = 1'b0;
  localparam logic ADDR_DATA  = 1'b1;

  typedef enum logic [1:0] {
    INIT,
    BUS,
    GAP,
    IDLE
  } state_t;

  // Power-up instruction sequence: clear, entry mode, display on.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = LCD_CLEAR;
      2'd1:    init_cmd = LCD_ENTRY;
      default: init_cmd = LCD_DISP_ON;
    endcase
  endfunction

endpackage

// File: rtl/avm_single_write.sv
// Single Avalon-MM write engine: registers one write on req and holds it until the slave accepts.
// Latency: outputs go active at the req edge; done/timeout pulse in the final cycle of the transfer.
// Backpressure: holds address/data/write stable under waitrequest; abandons after WAIT_TIMEOUT stall cycles.
//
// Ports: clk, reset (sync, active low); req/addr/data start a write (ignored while one is active);
//        waitrequest from the slave; done = accepted this cycle, timeout = abandoned this cycle;
//        address/chipselect/write/writedata/read drive the Avalon slave (read is tied low).
module avm_single_write #(
  parameter int WAIT_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       addr,
  input  logic [7:0] data,
  input  logic       waitrequest,
  output logic       done,
  output logic       timeout,
  output logic       address,
  output logic       chipselect,
  output logic       write,
  output logic [7:0] writedata,
  output logic       read
);

  localparam int CW = $clog2(WAIT_TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  assign done    = write & ~waitrequest;
  // wait_cnt counts stalled cycles already spent, so the write is high for exactly WAIT_TIMEOUT cycles
  assign timeout = write & waitrequest & (wait_cnt == CW'(WAIT_TIMEOUT - 1));
  assign read    = 1'b0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      write      <= 1'b0;
      chipselect <= 1'b0;
      address    <= 1'b0;
      writedata  <= 8'h00;
      wait_cnt   <= '0;
    end else if (write) begin
      if (done || timeout) begin
        write      <= 1'b0;
        chipselect <= 1'b0;
        wait_cnt   <= '0;
      end else begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end else if (req) begin
      write      <= 1'b1;
      chipselect <= 1'b1;
      address    <= addr;
      writedata  <= data;
      wait_cnt   <= '0;
    end
  end

endmodule

// File: rtl/lcd_text_writer.sv
// Byte-stream to character-LCD writer: runs panel init, tracks the cursor, wraps rows, handles LF/FF/clear.
// Latency: a byte accepted at an edge drives write from that edge; min 3 cycles per printable character.
// Backpressure: char_ready only in IDLE with no clear outstanding; Avalon waitrequest stalls the sequence.
//
// Ports: clk, reset (sync, active low); char_valid/char_data/char_ready byte input handshake;
//        clear_req one-cycle clear request; address/chipselect/write/writedata/read/waitrequest Avalon master;
//        busy, error (sticky timeout flag), cursor_col/cursor_row current cursor position.
module lcd_text_writer
  import lcd_pkg::*;
#(
  parameter int         COLS         = 16,
  parameter logic [7:0] ROW1_BASE    = 8'h40,
  parameter int         WAIT_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  input  logic       clear_req,
  output logic       address,
  output logic       chipselect,
  output logic       write,
  output logic [7:0] writedata,
  output logic       read,
  input  logic       waitrequest,
  output logic       busy,
  output logic       error,
  output logic [3:0] cursor_col,
  output logic       cursor_row
);

  state_t     state, state_n;
  logic [1:0] init_idx, init_idx_n;     // init commands issued so far; 3 = init finished
  logic       pend_vld, pend_vld_n;     // follow-up set-address instruction after a row wrap
  logic [7:0] pend_dat, pend_dat_n;
  logic       clear_pending, clear_pending_n;
  logic       error_n;
  logic [3:0] col_n;
  logic       row_n;
  logic       req, req_addr;
  logic [7:0] req_dat;
  logic       done, timeout;

  function automatic logic [7:0] set_addr(input logic row);
    return LCD_SET_DDRAM | (row ? ROW1_BASE : 8'h00);
  endfunction

  avm_single_write #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) u_avm (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .addr       (req_addr),
    .data       (req_dat),
    .waitrequest(waitrequest),
    .done       (done),
    .timeout    (timeout),
    .address    (address),
    .chipselect (chipselect),
    .write      (write),
    .writedata  (writedata),
    .read       (read)
  );

  assign char_ready = reset & (state == IDLE) & ~clear_req & ~clear_pending;
  assign busy       = (state != IDLE) | clear_pending;

  always_comb begin
    state_n         = state;
    init_idx_n      = init_idx;
    pend_vld_n      = pend_vld;
    pend_dat_n      = pend_dat;
    clear_pending_n = clear_pending | clear_req;
    error_n         = error;
    col_n           = cursor_col;
    row_n           = cursor_row;
    req             = 1'b0;
    req_addr        = ADDR_INSTR;
    req_dat         = 8'h00;
    case (state)
      INIT: begin
        req        = 1'b1;
        req_dat    = init_cmd(2'd0);
        init_idx_n = 2'd1;
        state_n    = BUS;
      end
      BUS: begin
        if (timeout) begin
          // drop whatever remains of this command sequence, cursor stays as updated
          error_n    = 1'b1;
          pend_vld_n = 1'b0;
          init_idx_n = 2'd3;
          state_n    = GAP;
        end else if (done) begin
          state_n = GAP;
        end
      end
      GAP: begin
        if (init_idx != 2'd3) begin
          req        = 1'b1;
          req_dat    = init_cmd(init_idx);
          init_idx_n = init_idx + 2'd1;
          state_n    = BUS;
        end else if (pend_vld) begin
          req        = 1'b1;
          req_dat    = pend_dat;
          pend_vld_n = 1'b0;
          state_n    = BUS;
        end else begin
          state_n = IDLE;
        end
      end
      IDLE: begin
        if (clear_req || clear_pending) begin
          // clear has priority over a byte offered in the same cycle
          req             = 1'b1;
          req_dat         = LCD_CLEAR;
          clear_pending_n = 1'b0;
          col_n           = 4'd0;
          row_n           = 1'b0;
          state_n         = BUS;
        end else if (char_valid) begin
          if (char_data >= 8'h20 && char_data <= 8'h7E) begin
            req      = 1'b1;
            req_addr = ADDR_DATA;
            req_dat  = char_data;
            state_n  = BUS;
            if (cursor_col == 4'(COLS - 1)) begin
              col_n      = 4'd0;
              row_n      = ~cursor_row;
              pend_vld_n = 1'b1;
              pend_dat_n = set_addr(~cursor_row);
            end else begin
              col_n = cursor_col + 4'd1;
            end
          end else if (char_data == CH_LF) begin
            req     = 1'b1;
            req_dat = set_addr(~cursor_row);
            col_n   = 4'd0;
            row_n   = ~cursor_row;
            state_n = BUS;
          end else if (char_data == CH_FF) begin
            req     = 1'b1;
            req_dat = LCD_CLEAR;
            col_n   = 4'd0;
            row_n   = 1'b0;
            state_n = BUS;
          end
          // any other byte is consumed without bus activity
        end
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= INIT;
      init_idx      <= 2'd0;
      pend_vld      <= 1'b0;
      pend_dat      <= 8'h00;
      clear_pending <= 1'b0;
      error         <= 1'b0;
      cursor_col    <= 4'd0;
      cursor_row    <= 1'b0;
    end else begin
      state         <= state_n;
      init_idx      <= init_idx_n;
      pend_vld      <= pend_vld_n;
      pend_dat      <= pend_dat_n;
      clear_pending <= clear_pending_n;
      error         <= error_n;
      cursor_col    <= col_n;
      cursor_row    <= row_n;
    end
  end

endmodule
